// File: rtl/tx_pack_10b_to_20b.sv
// tx_pack_10b_to_20b
// Packs pairs of 10b code groups into 20b words for the transceiver TX bus.
// A small symbol FIFO decouples the encoder from the output handshake. A single
// held symbol can be flushed out with PAD_SYM in its partner position.
module tx_pack_10b_to_20b #(
    parameter bit         UPPER_FIRST = 1'b1,
    parameter bit         ROT_OUT     = 1'b1,
    parameter logic [9:0] PAD_SYM     = 10'b0011111010,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [9:0]                    tenb,
    input  logic                          tenb_valid,
    output logic                          tenb_ready,
    input  logic                          flush,
    output logic [19:0]                   twenb,
    output logic                          twenb_valid,
    input  logic                          twenb_ready,
    output logic                          pad_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic          push;
    logic          slot_free;
    logic          load_pair;
    logic          load_pad;
    logic [1:0]    pop_cnt;
    logic [9:0]    s0;
    logic [9:0]    s1;
    logic [9:0]    s1_sel;
    logic [19:0]   word;
    logic [19:0]   word_out;

    // Ready comes from the registered count only, so a same-cycle pop never
    // opens the input path combinationally.
    assign tenb_ready = (fifo_level < LW'(FIFO_DEPTH));
    assign push       = tenb_valid & tenb_ready;
    assign slot_free  = ~twenb_valid | twenb_ready;
    assign load_pair  = slot_free && (fifo_level >= LW'(2));
    assign load_pad   = slot_free && (fifo_level == LW'(1)) && flush;

    assign rd_ptr_nxt = rd_ptr + PW'(1);
    assign s0         = mem[rd_ptr];
    assign s1         = mem[rd_ptr_nxt];
    assign s1_sel     = load_pad ? PAD_SYM : s1;
    assign word       = UPPER_FIRST ? {s0, s1_sel} : {s1_sel, s0};
    // Right rotation undoes the 1-bit left rotation done by the RX unpacker.
    assign word_out   = ROT_OUT ? {word[0], word[19:1]} : word;

    // Number of symbols leaving the FIFO this cycle.
    always_comb begin
        pop_cnt = 2'd0;
        if (load_pair) begin
            pop_cnt = 2'd2;
        end else if (load_pad) begin
            pop_cnt = 2'd1;
        end
    end

    // Symbol storage; data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tenb;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_ptr + PW'(pop_cnt);
            fifo_level <= fifo_level + LW'(push) - LW'(pop_cnt);
        end
    end

    // Output word register: loads when the slot is free, holds under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            twenb       <= '0;
            twenb_valid <= 1'b0;
            pad_flag    <= 1'b0;
        end else if (load_pair || load_pad) begin
            twenb       <= word_out;
            twenb_valid <= 1'b1;
            pad_flag    <= load_pad;
        end else if (slot_free) begin
            twenb_valid <= 1'b0;
            pad_flag    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_pack_10b_to_20b.sv
// Bench for tx_pack_10b_to_20b: three instances with different packing options
// share one stimulus stream; each has its own expected-word queue.
module tb_tx_pack_10b_to_20b;

    logic        clk;
    logic        rst_n;
    logic [9:0]  tenb;
    logic        tenb_valid;
    logic        flush;
    logic        twenb_ready;
    logic        rdy [3];
    logic [19:0] tw [3];
    logic        tw_valid [3];
    logic        pad [3];
    logic [2:0]  lvl [3];

    int checks = 0;
    int errors = 0;

    logic [20:0] q0[$];
    logic [20:0] q1[$];
    logic [20:0] q2[$];

    logic        stall_prev = 1'b0;
    logic [20:0] stall_word = '0;

    // dut 0: upper first, no rotation
    tx_pack_10b_to_20b #(.UPPER_FIRST(1'b1), .ROT_OUT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tenb(tenb), .tenb_valid(tenb_valid),
        .tenb_ready(rdy[0]), .flush(flush), .twenb(tw[0]), .twenb_valid(tw_valid[0]),
        .twenb_ready(twenb_ready), .pad_flag(pad[0]), .fifo_level(lvl[0]));

    // dut 1: upper first, rotated
    tx_pack_10b_to_20b #(.UPPER_FIRST(1'b1), .ROT_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tenb(tenb), .tenb_valid(tenb_valid),
        .tenb_ready(rdy[1]), .flush(flush), .twenb(tw[1]), .twenb_valid(tw_valid[1]),
        .twenb_ready(twenb_ready), .pad_flag(pad[1]), .fifo_level(lvl[1]));

    // dut 2: lower first, no rotation
    tx_pack_10b_to_20b #(.UPPER_FIRST(1'b0), .ROT_OUT(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tenb(tenb), .tenb_valid(tenb_valid),
        .tenb_ready(rdy[2]), .flush(flush), .twenb(tw[2]), .twenb_valid(tw_valid[2]),
        .twenb_ready(twenb_ready), .pad_flag(pad[2]), .fifo_level(lvl[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pack(input logic [9:0] a, input logic [9:0] b,
                                         input bit uf, input bit rot);
        logic [19:0] w;
        w = uf ? {a, b} : {b, a};
        return rot ? {w[0], w[19:1]} : w;
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_words(input logic [19:0] w0, input logic [19:0] w1,
                                input logic [19:0] w2, input logic p);
        q0.push_back({p, w0});
        q1.push_back({p, w1});
        q2.push_back({p, w2});
    endtask

    task automatic expect_pair(input logic [9:0] a, input logic [9:0] b);
        expect_words(pack(a, b, 1, 0), pack(a, b, 1, 1), pack(a, b, 0, 0), 1'b0);
    endtask

    task automatic check_word(input int k);
        logic [20:0] e;
        logic        empty;
        empty = 1'b0;
        e = '0;
        case (k)
            0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
        endcase
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL unexpected_word dut%0d got %h pad %0d expected none", k, tw[k], pad[k]);
        end else if ({pad[k], tw[k]} !== e) begin
            errors++;
            $display("FAIL word dut%0d got pad %0d %h expected pad %0d %h",
                     k, pad[k], tw[k], e[20], e[19:0]);
        end
    endtask

    // Monitor: every accepted word is compared against its queue head; a
    // stalled word on dut0 must not change until accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (tw_valid[k] && twenb_ready) check_word(k);
            end
            if (stall_prev) begin
                checks++;
                if (!tw_valid[0] || {pad[0], tw[0]} !== stall_word) begin
                    errors++;
                    $display("FAIL stall_hold got v%0d %h expected v1 %h",
                             tw_valid[0], {pad[0], tw[0]}, stall_word);
                end
            end
            stall_prev = tw_valid[0] && !twenb_ready;
            stall_word = {pad[0], tw[0]};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending expected 0", nm,
                     q0.size() + q1.size() + q2.size());
        end
    endtask

    logic [9:0] syms [8];
    logic [9:0] acc_q[$];

    initial begin
        rst_n       = 1'b0;
        tenb        = '0;
        tenb_valid  = 1'b0;
        flush       = 1'b0;
        twenb_ready = 1'b1;
        syms = '{10'h3A1, 10'h05C, 10'h2E7, 10'h118, 10'h0F3, 10'h36D, 10'h24B, 10'h1B4};

        #12;
        chk("rst_twenb", tw[0], 20'h0);
        chk("rst_valid", {19'h0, tw_valid[0]}, 20'h0);
        chk("rst_pad", {19'h0, pad[0]}, 20'h0);
        chk("rst_level", {17'h0, lvl[0]}, 20'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {19'h0, rdy[0]}, 20'h1);

        // Basic pair with latency checks
        tenb = 10'h17C; tenb_valid = 1'b1;
        tick();
        tenb = 10'h283;
        expect_words(20'h5F283, 20'hAF941, 20'hA0D7C, 1'b0);
        tick();
        tenb_valid = 1'b0;
        chk("lat_level2", {17'h0, lvl[0]}, 20'h2);
        chk("lat_notyet", {19'h0, tw_valid[0]}, 20'h0);
        tick();
        chk("lat_valid", {19'h0, tw_valid[0]}, 20'h1);
        chk("lat_pad0", {19'h0, pad[0]}, 20'h0);
        tick();
        chk("valid_clear", {19'h0, tw_valid[0]}, 20'h0);

        // Second pair, distinct bit pattern
        tenb = 10'h001; tenb_valid = 1'b1;
        tick();
        tenb = 10'h3FF;
        expect_words(20'h007FF, 20'h803FF, 20'hFFC01, 1'b0);
        tick();
        tenb_valid = 1'b0;
        tick(); tick();

        // Flush on an empty FIFO does nothing
        flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        chk("flush_empty", {19'h0, tw_valid[0]}, 20'h0);

        // Flush of a single held symbol
        tenb = 10'h283; tenb_valid = 1'b1;
        tick();
        tenb_valid = 1'b0;
        chk("flush_lvl1", {17'h0, lvl[0]}, 20'h1);
        flush = 1'b1;
        expect_words(20'hA0CFA, 20'h5067D, 20'h3EA83, 1'b1);
        tick();
        flush = 1'b0;
        chk("flush_lvl0", {17'h0, lvl[0]}, 20'h0);
        chk("flush_pad", {19'h0, pad[0]}, 20'h1);
        tick();
        chk("flush_padclr", {19'h0, pad[0]}, 20'h0);

        // Back-pressure: offer 8 symbols with the output blocked
        twenb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tenb = syms[i]; tenb_valid = 1'b1;
            if (rdy[0]) acc_q.push_back(syms[i]);
            tick();
        end
        tenb_valid = 1'b0;
        chk("bp_accepted", 20'(acc_q.size()), 20'd6);
        chk("bp_full_ready", {19'h0, rdy[0]}, 20'h0);
        chk("bp_level", {17'h0, lvl[0]}, 20'h4);
        for (int i = 0; i < 3; i++) begin
            chk("bp_order", {10'h0, acc_q[2*i]}, {10'h0, syms[2*i]});
            expect_pair(acc_q[2*i], acc_q[2*i+1]);
        end
        tick();
        twenb_ready = 1'b1;
        drain("bp");

        // Streaming one symbol per clock: input never stalls
        for (int i = 0; i < 8; i++) begin
            tenb = 10'(i * 73 + 5); tenb_valid = 1'b1;
            chk("stream_ready", {19'h0, rdy[0]}, 20'h1);
            if (i % 2 == 1) expect_pair(10'((i - 1) * 73 + 5), 10'(i * 73 + 5));
            tick();
        end
        tenb_valid = 1'b0;
        drain("stream");

        // Reset in the middle of a stream with one symbol held
        tenb = 10'h111; tenb_valid = 1'b1;
        tick();
        tenb = 10'h222;
        chk("mid_lvl1", {17'h0, lvl[0]}, 20'h1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mrst_twenb", tw[k], 20'h0);
            chk("mrst_valid", {19'h0, tw_valid[k]}, 20'h0);
        end
        chk("mrst_pad", {19'h0, pad[0]}, 20'h0);
        chk("mrst_level", {17'h0, lvl[0]}, 20'h0);
        tenb_valid = 1'b0;
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();
        chk("mrst_ready", {19'h0, rdy[0]}, 20'h1);
        tenb = 10'h2AA; tenb_valid = 1'b1;
        tick();
        tenb = 10'h155;
        expect_pair(10'h2AA, 10'h155);
        tick();
        tenb_valid = 1'b0;
        drain("post_rst");
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_pack_10b_to_20b.md
TX_PACK_10B_TO_20B -- requirements
Module: tx_pack_10b_to_20b

Interface
REQ-001 SHALL have parameter UPPER_FIRST, default 1, meaning the first symbol of a pair goes to word[19:10] (0: word[9:0]).
REQ-002 SHALL have parameter ROT_OUT, default 1, meaning the assembled word is rotated right by one bit before output; this is the inverse of the 1-bit left rotation applied by the RX unpacker.
REQ-003 SHALL have parameter PAD_SYM, default 10'b0011111010 (K28.5 RD-), meaning the symbol inserted by flush.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), meaning the input symbol FIFO depth.
REQ-005 clk  input  1  TXUSRCLK2-domain clock; the only clock.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 tenb  input  10  10b code group from the encoder.
REQ-008 tenb_valid  input  1  tenb is valid this cycle.
REQ-009 tenb_ready  output  1  FIFO can accept a symbol this cycle.
REQ-010 flush  input  1  request to emit a held odd symbol padded with PAD_SYM.
REQ-011 twenb  output  20  packed word to the transceiver TX data bus.
REQ-012 twenb_valid  output  1  twenb holds an unaccepted word.
REQ-013 twenb_ready  input  1  transceiver side accepts twenb this cycle.
REQ-014 pad_flag  output  1  current twenb contains a PAD_SYM half.
REQ-015 fifo_level  output  clog2(FIFO_DEPTH)+1  registered FIFO occupancy.

Function
REQ-016 SHALL accept a symbol on any rising clk edge where tenb_valid and tenb_ready are both 1.
REQ-017 SHALL drive tenb_ready = (fifo_level < FIFO_DEPTH), from registered count only, not from the same-cycle pop.
REQ-018 SHALL allow push and pop on the same edge; fifo_level = old + push - pops; read/write pointers wrap modulo FIFO_DEPTH.
REQ-019 Output slot SHALL be free when twenb_valid=0 or twenb_ready=1.
REQ-020 When the slot is free and fifo_level>=2, SHALL pop two symbols (oldest = S0) on one edge and load the word, setting twenb_valid=1 and pad_flag=0.
REQ-021 Word SHALL be W={S0,S1} if UPPER_FIRST=1, else {S1,S0}; twenb=ROT_OUT ? {W[0],W[19:1]} : W.
REQ-022 When the slot is free, fifo_level==1 and flush=1, SHALL pop one symbol S0, load W with PAD_SYM in the S1 position, and set pad_flag=1.
REQ-023 flush SHALL be ignored when fifo_level is 0 or >=2, or when the slot is not free.
REQ-024 When the slot is free and no load occurs, SHALL clear twenb_valid and pad_flag; twenb SHALL hold its last value.
REQ-025 twenb, twenb_valid and pad_flag SHALL hold stable while twenb_valid=1 and twenb_ready=0.
REQ-026 Latency: the second symbol of a pair is accepted on edge E; fifo_level=2 after E; the word loads on E+1; twenb_valid=1 from E+1 (slot free).
REQ-027 Sustained throughput SHALL be one word per two clocks with one symbol per clock input and twenb_ready=1; no symbol is dropped, duplicated or reordered.

Reset
REQ-028 rst_n=0 SHALL immediately clear FIFO pointers, fifo_level=0, twenb=0, twenb_valid=0, pad_flag=0; tenb_ready=1 after deassertion.
REQ-029 Reset mid-operation SHALL discard all buffered symbols and any unaccepted word; the first post-reset symbol is S0 of a new pair.
REQ-030 rst_n deassertion is synchronised externally; the block SHALL need no extra reset sequencing.

Verification
REQ-031 UPPER_FIRST=1, ROT_OUT=0, twenb_ready=1; push 10'h17C then 10'h283 -> twenb=20'h5F283, pad_flag=0, valid 2 edges after second push.
REQ-032 Same stimulus, ROT_OUT=1 -> twenb=20'hAF941.
REQ-033 ROT_OUT=0, push only 10'h283, then flush=1 -> twenb=20'hA0CFA, pad_flag=1, fifo_level=0.
REQ-034 twenb_ready=0, offer 8 consecutive symbols -> 2 in the word plus FIFO_DEPTH in the FIFO; tenb_ready low when full; after release, the word order matches the input order exactly.
REQ-035 Continuous pushes with fifo_level=1, pulse rst_n low -> all outputs 0 at once; post-reset pair {A,B} emitted with A first, no stale data.
REQ-036 UPPER_FIRST=0, push A=10'h001, B=10'h3FF, ROT_OUT=0 -> twenb=20'hFFC01.
